// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared types and default constants for the push-button conditioner.
//   btn_state_t        : per-channel debounce FSM states
//   DB_CYCLES_DEF      : default debounce length (10 ms at 100 MHz)
//   REPEAT_DELAY_DEF   : default hold time before the first auto-repeat
//   REPEAT_PERIOD_DEF  : default spacing of later auto-repeats
//   cnt_width()        : width of a counter that must hold 0..max_val
// The repeat constants only matter when AUTO_REPEAT_EN is defined.
// ---------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM_ON,
        S_HELD,
        S_ARM_OFF
    } btn_state_t;

    localparam int DB_CYCLES_DEF     = 1_000_000;
    localparam int REPEAT_DELAY_DEF  = 50_000_000;
    localparam int REPEAT_PERIOD_DEF = 10_000_000;

    // Width needed to represent 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// ---------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: synchroniser, debounce FSM, debounce counter and
// registered press/release pulses. With AUTO_REPEAT_EN defined, a repeat
// counter also re-fires the press pulse while the button stays held.
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   raw        in   raw button pin, active-high, asynchronous to clk
//   level      out  debounced level
//   press      out  one-cycle pulse on accepted press (and repeats)
//   rel        out  one-cycle pulse on accepted release
//   press_next out  value press takes on the next edge, lets the parent
//                   register an aggregate pulse aligned with press
// Requires SYNC_STAGES >= 2 and DB_CYCLES >= 2.
// Macro: AUTO_REPEAT_EN enables the auto-repeat counter.
// ---------------------------------------------------------------------------
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = DB_CYCLES_DEF
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic press_next
);

    localparam int CW = cnt_width(DB_CYCLES);

    // The edge that moves the FSM out of IDLE/HELD already counts as the
    // first stable sample, so the hand-over happens when the counter is
    // about to become DB_CYCLES-1, i.e. when it currently reads DB_CYCLES-2.
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DB_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    btn_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic level_q, level_d;
    logic press_q, press_d, press_fsm;
    logic rel_q, rel_d;
    logic rep_fire;

    // Plain flop chain to bring the asynchronous pin into the clk domain;
    // only the last stage is ever looked at by the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Saturating increment so a mis-sized parameter can never wrap the count.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    // State, counter and output registers. Pulses and level are registered
    // together so they all change on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    // Debounce FSM: an input change must persist for DB_CYCLES samples
    // before it is accepted; any reversion while arming drops back without
    // producing a pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_fsm = 1'b0;
        rel_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                level_d = 1'b0;
                cnt_d   = '0;
                if (s) begin
                    state_d = S_ARM_ON;
                end
            end
            S_ARM_ON: begin
                if (!s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_HELD;
                    cnt_d     = '0;
                    level_d   = 1'b1;
                    press_fsm = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_HELD: begin
                level_d = 1'b1;
                cnt_d   = '0;
                if (!s) begin
                    state_d = S_ARM_OFF;
                end
            end
            S_ARM_OFF: begin
                if (s) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

    logic [RW-1:0] rcnt_q, rcnt_d, rlast;
    logic          rfirst_q, rfirst_d;

    // Repeat counter and the flag telling whether the initial delay has
    // already elapsed (after which the shorter period applies).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rcnt_q   <= '0;
            rfirst_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            rfirst_q <= rfirst_d;
        end
    end

    assign rlast = rfirst_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);

    // Runs only while the channel stays in HELD with the input still high;
    // the cycle that leaves HELD (or any other state) clears it, so a return
    // from ARM_OFF starts again from the full initial delay.
    always_comb begin
        rcnt_d   = '0;
        rfirst_d = 1'b0;
        rep_fire = 1'b0;
        if (state_q == S_HELD && s) begin
            rfirst_d = rfirst_q;
            if (rcnt_q == rlast) begin
                rep_fire = 1'b1;
                rfirst_d = 1'b1;
            end else begin
                rcnt_d = rcnt_q + RW'(1);
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // A repeat only fires while staying in HELD, and the FSM press only on
    // entering HELD, so the two never coincide and never overlap a release.
    assign press_d = press_fsm | rep_fire;

    assign level      = level_q;
    assign press      = press_q;
    assign rel        = rel_q;
    assign press_next = press_d;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Cleans up the board push-buttons before they reach the game logic:
// each channel is synchronised and debounced, and produces a clean level
// plus one-cycle press/release pulses so a move advances once per press.
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset; its release is
//                     expected to be synchronous to clk already
//   btn_raw      in   [N_BTN] raw button pins, active-high, asynchronous
//   btn_level    out  [N_BTN] debounced levels
//   btn_press    out  [N_BTN] press pulses (and repeats when enabled)
//   btn_release  out  [N_BTN] release pulses
//   any_press    out  OR of btn_press, registered in the same cycle
// Macro: AUTO_REPEAT_EN adds auto-repeat press pulses while a button is held.
// ---------------------------------------------------------------------------
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = DB_CYCLES_DEF
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_press
);

    logic [N_BTN-1:0] press_next;

    // Channels are completely independent; simultaneous presses simply
    // produce simultaneous pulses.
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DB_CYCLES     (DB_CYCLES)
`ifdef AUTO_REPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .raw        (btn_raw[i]),
            .level      (btn_level[i]),
            .press      (btn_press[i]),
            .rel        (btn_release[i]),
            .press_next (press_next[i])
        );
    end

    // Registering the OR of the channels' next-press values keeps any_press
    // on exactly the same edge as btn_press while still coming from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_next;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Scoreboard bench: each stimulus pushes the pulse it should cause (cycle
// and press/release/any vector) and a negedge monitor pops and compares
// whenever the DUT pulses. Runs with DB_CYCLES=4, SYNC_STAGES=2 and, when
// AUTO_REPEAT_EN is defined, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int NB  = 4;
    localparam int LAT = 6;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release;
    logic          any_press;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int t0, t1;

    typedef struct {
        int         due;
        logic [8:0] vec;
    } exp_t;

    exp_t expq[$];

    button_conditioner #(
        .N_BTN         (NB),
        .SYNC_STAGES   (2),
        .DB_CYCLES     (4)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (8)
`endif
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_press   (any_press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Drive the raw buttons on a falling edge, away from the sampling edge.
    task automatic applyStimulus(input logic [NB-1:0] v);
        @(negedge clk);
        btn_raw = v;
    endtask

    task automatic pushExp(input int due, input logic [NB-1:0] p, input logic [NB-1:0] r);
        exp_t e;
        e.due = due;
        e.vec = {p, r, |p};
        expq.push_back(e);
    endtask

    task automatic drain();
        int waited = 0;
        while (expq.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        #1;
        checkOutput("queue_drained", 32'(expq.size()), 32'd0);
        expq.delete();
    endtask

    // Monitor: flags overdue expectations, then matches every pulse seen.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            while (expq.size() > 0 && expq[0].due < cyc) begin
                checkOutput("missing_pulse", 32'(cyc), 32'(expq[0].due));
                void'(expq.pop_front());
            end
            if ((btn_press | btn_release) != '0 || any_press) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_pulse", {23'd0, btn_press, btn_release, any_press}, 32'd0);
                end else begin
                    e = expq.pop_front();
                    checkOutput("pulse_cycle", 32'(cyc), 32'(e.due));
                    checkOutput("pulse_value", {23'd0, btn_press, btn_release, any_press}, {23'd0, e.vec});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting button_conditioner bench");

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_outputs", {19'd0, btn_level, btn_press, btn_release, any_press}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1. Clean press on button 0, held 30 cycles
        applyStimulus(4'b0001);
        t0 = cyc;
        pushExp(t0 + LAT, 4'b0001, 4'b0000);
`ifdef AUTO_REPEAT_EN
        pushExp(t0 + 26, 4'b0001, 4'b0000);
`endif
        repeat (LAT - 1) @(negedge clk);
        checkOutput("t1_level_before", 32'(btn_level[0]), 32'd0);
        @(negedge clk);
        checkOutput("t1_level_after", 32'(btn_level[0]), 32'd1);
        repeat (23) @(negedge clk);
        applyStimulus(4'b0000);
        t1 = cyc;
        pushExp(t1 + LAT, 4'b0000, 4'b0001);
        drain();
        checkOutput("t1_level_released", 32'(btn_level), 32'd0);

        // 2. Glitch on button 1: high 3 cycles is rejected
        applyStimulus(4'b0010);
        repeat (2) @(negedge clk);
        applyStimulus(4'b0000);
        repeat (10) @(negedge clk);
        checkOutput("t2_glitch_level", 32'(btn_level[1]), 32'd0);

        // 2b. Boundary: high exactly 4 cycles is accepted
        applyStimulus(4'b0010);
        t0 = cyc;
        pushExp(t0 + LAT, 4'b0010, 4'b0000);
        repeat (3) @(negedge clk);
        applyStimulus(4'b0000);
        t1 = cyc;
        pushExp(t1 + LAT, 4'b0000, 4'b0010);
        drain();

        // 3. Bounce on button 2: toggle every 2 cycles, then stay high
        for (int k = 0; k < 4; k++) begin
            applyStimulus((k % 2 == 0) ? 4'b0100 : 4'b0000);
            @(negedge clk);
        end
        applyStimulus(4'b0100);
        t0 = cyc;
        pushExp(t0 + LAT, 4'b0100, 4'b0000);
        repeat (10) @(negedge clk);
        checkOutput("t3_level", 32'(btn_level), 32'h4);
        applyStimulus(4'b0000);
        pushExp(cyc + LAT, 4'b0000, 4'b0100);
        drain();

        // 4. All four buttons together
        applyStimulus(4'b1111);
        pushExp(cyc + LAT, 4'b1111, 4'b0000);
        repeat (10) @(negedge clk);
        checkOutput("t4_level", 32'(btn_level), 32'hF);
        applyStimulus(4'b0000);
        pushExp(cyc + LAT, 4'b0000, 4'b1111);
        drain();

        // 5. Reset while button 0 is arming and button 1 is held
        applyStimulus(4'b0010);
        pushExp(cyc + LAT, 4'b0010, 4'b0000);
        drain();
        checkOutput("t5_level_pre", 32'(btn_level), 32'h2);
        applyStimulus(4'b0011);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("t5_async_reset", {19'd0, btn_level, btn_press, btn_release, any_press}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        t1 = cyc;
        pushExp(t1 + LAT, 4'b0011, 4'b0000);
        drain();
        checkOutput("t5_level_post", 32'(btn_level), 32'h3);
        applyStimulus(4'b0000);
        pushExp(cyc + LAT, 4'b0000, 4'b0011);
        drain();

        // 6. Long hold on button 3 (auto-repeat when enabled)
        applyStimulus(4'b1000);
        t0 = cyc;
        pushExp(t0 + LAT, 4'b1000, 4'b0000);
`ifdef AUTO_REPEAT_EN
        for (int r = 26; r < 60; r += 8) pushExp(t0 + r, 4'b1000, 4'b0000);
`endif
        repeat (30) @(negedge clk);
        checkOutput("t6_level_held", 32'(btn_level), 32'h8);
        repeat (29) @(negedge clk);
        applyStimulus(4'b0000);
        pushExp(cyc + LAT, 4'b0000, 4'b1000);
        drain();
        repeat (5) @(negedge clk);
        checkOutput("final_level", 32'(btn_level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
